// File: rtl/load_store_unit.sv
// Load/store unit: aligns byte/half/word/double accesses onto the XLEN data bus and
// extends load data. Optional ACCESS watchdog is enabled by defining LSU_TIMEOUT_EN.
module load_store_unit #(
    parameter int XLEN           = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [1:0]        req_width,
    input  logic              req_unsigned,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_load_misalign,
    output logic              resp_store_misalign,
    output logic              resp_fault,
    output logic              dmem_ren,
    output logic              dmem_wen,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [XLEN/8-1:0] dmem_be,
    output logic [XLEN-1:0]   dmem_store,
    input  logic [XLEN-1:0]   dmem_load,
    input  logic              dhit
);

    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state, state_next;
    logic              r_wen;
    logic              r_unsigned;
    logic [1:0]        r_width;
    logic [XLEN-1:0]   r_addr;
    logic [XLEN-1:0]   r_wdata;
    logic [OW-1:0]     offset;
    logic [NB-1:0]     width_mask;
    logic [XLEN-1:0]   keep_mask;
    logic [XLEN-1:0]   load_shifted;
    logic              load_sign;
    logic [XLEN-1:0]   load_ext;
    logic              req_misaligned;
    logic              timeout_hit;

    function automatic logic is_misaligned(input logic [1:0] width, input logic [2:0] addr);
        case (width)
            2'b00:   return 1'b0;
            2'b01:   return addr[0];
            2'b10:   return addr[1:0] != 2'b00;
            default: return (XLEN == 32) ? 1'b1 : (addr != 3'b000);
        endcase
    endfunction

    assign req_misaligned = is_misaligned(req_width, req_addr[2:0]);
    assign offset         = r_addr[OW-1:0];

    always_comb begin
        width_mask = '0;
        keep_mask  = '0;
        load_sign  = 1'b0;
        load_shifted = dmem_load >> {offset, 3'b000};
        case (r_width)
            2'b00: begin
                width_mask = NB'(8'h01);
                keep_mask  = XLEN'(8'hFF);
                load_sign  = load_shifted[7];
            end
            2'b01: begin
                width_mask = NB'(8'h03);
                keep_mask  = XLEN'(16'hFFFF);
                load_sign  = load_shifted[15];
            end
            2'b10: begin
                width_mask = NB'(8'h0F);
                keep_mask  = XLEN'(32'hFFFF_FFFF);
                load_sign  = load_shifted[31];
            end
            default: begin
                width_mask = NB'(8'hFF);
                keep_mask  = '1;
                load_sign  = load_shifted[XLEN-1];
            end
        endcase
        load_ext = load_shifted & keep_mask;
        if (!r_unsigned && load_sign) begin
            load_ext = load_ext | ~keep_mask;
        end
    end

    // Bus strobes depend on registered state only, never on dhit.
    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign dmem_ren   = (state == ACCESS) && !r_wen;
    assign dmem_wen   = (state == ACCESS) && r_wen;
    assign dmem_addr  = (state == ACCESS) ? {r_addr[XLEN-1:OW], {OW{1'b0}}} : '0;
    assign dmem_be    = (state == ACCESS) ? (width_mask << offset) : '0;
    assign dmem_store = dmem_wen ? (r_wdata << {offset, 3'b000}) : '0;

`ifdef LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wd_count;

    assign timeout_hit = (state == ACCESS) && !dhit && (wd_count == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || state != ACCESS) begin
            wd_count <= '0;
        end else if (!dhit) begin
            wd_count <= wd_count + 1'b1;
        end
    end

    // Fault flag changes only when a response is produced, so it holds like the others.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_fault <= 1'b0;
        end else if (state == IDLE && req_valid && req_misaligned) begin
            resp_fault <= 1'b0;
        end else if (state == ACCESS && dhit) begin
            resp_fault <= 1'b0;
        end else if (timeout_hit) begin
            resp_fault <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign resp_fault  = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = req_misaligned ? RESP : ACCESS;
            ACCESS:  if (dhit || timeout_hit) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Response data and misalign flags are only written on the way into RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= IDLE;
            r_wen               <= 1'b0;
            r_unsigned          <= 1'b0;
            r_width             <= 2'b00;
            r_addr              <= '0;
            r_wdata             <= '0;
            resp_rdata          <= '0;
            resp_load_misalign  <= 1'b0;
            resp_store_misalign <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        r_wen      <= req_wen;
                        r_unsigned <= req_unsigned;
                        r_width    <= req_width;
                        r_addr     <= req_addr;
                        r_wdata    <= req_wdata;
                        if (req_misaligned) begin
                            resp_rdata          <= '0;
                            resp_load_misalign  <= !req_wen;
                            resp_store_misalign <= req_wen;
                        end
                    end
                end
                ACCESS: begin
                    if (dhit) begin
                        resp_rdata          <= r_wen ? '0 : load_ext;
                        resp_load_misalign  <= 1'b0;
                        resp_store_misalign <= 1'b0;
                    end else if (timeout_hit) begin
                        resp_rdata          <= '0;
                        resp_load_misalign  <= 1'b0;
                        resp_store_misalign <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench: one 32-bit and one 64-bit unit share stimulus, checked against
// a byte-arithmetic reference model; the watchdog checks follow LSU_TIMEOUT_EN.
module tb_load_store_unit;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst, sel64, req_valid, req_wen, req_unsigned, dhit;
    logic [63:0] req_addr, req_wdata, dmem_load;
    logic [1:0]  req_width;

    logic        a_ready, a_valid, a_lm, a_sm, a_fault, a_ren, a_wen;
    logic [31:0] a_rdata, a_addr, a_store;
    logic [3:0]  a_be;
    logic        b_ready, b_valid, b_lm, b_sm, b_fault, b_ren, b_wen;
    logic [63:0] b_rdata, b_addr, b_store;
    logic [7:0]  b_be;

    logic        o_ready, o_valid, o_lm, o_sm, o_fault, o_ren, o_wen;
    logic [63:0] o_rdata, o_addr, o_store;
    logic [7:0]  o_be;

    int          total = 0;
    int          passed = 0;
    logic [63:0] prev_rdata [2];
    logic [2:0]  prev_flags [2];

    always #5 clk = ~clk;

    load_store_unit #(.XLEN(32), .TIMEOUT_CYCLES(TO)) dut32 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid & ~sel64), .req_ready(a_ready),
        .req_wen(req_wen), .req_addr(req_addr[31:0]), .req_wdata(req_wdata[31:0]),
        .req_width(req_width), .req_unsigned(req_unsigned),
        .resp_valid(a_valid), .resp_rdata(a_rdata),
        .resp_load_misalign(a_lm), .resp_store_misalign(a_sm), .resp_fault(a_fault),
        .dmem_ren(a_ren), .dmem_wen(a_wen), .dmem_addr(a_addr), .dmem_be(a_be),
        .dmem_store(a_store), .dmem_load(dmem_load[31:0]), .dhit(dhit & ~sel64)
    );

    load_store_unit #(.XLEN(64), .TIMEOUT_CYCLES(TO)) dut64 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid & sel64), .req_ready(b_ready),
        .req_wen(req_wen), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_width(req_width), .req_unsigned(req_unsigned),
        .resp_valid(b_valid), .resp_rdata(b_rdata),
        .resp_load_misalign(b_lm), .resp_store_misalign(b_sm), .resp_fault(b_fault),
        .dmem_ren(b_ren), .dmem_wen(b_wen), .dmem_addr(b_addr), .dmem_be(b_be),
        .dmem_store(b_store), .dmem_load(dmem_load), .dhit(dhit & sel64)
    );

    assign o_ready = sel64 ? b_ready : a_ready;
    assign o_valid = sel64 ? b_valid : a_valid;
    assign o_lm    = sel64 ? b_lm    : a_lm;
    assign o_sm    = sel64 ? b_sm    : a_sm;
    assign o_fault = sel64 ? b_fault : a_fault;
    assign o_ren   = sel64 ? b_ren   : a_ren;
    assign o_wen   = sel64 ? b_wen   : a_wen;
    assign o_rdata = sel64 ? b_rdata : {32'b0, a_rdata};
    assign o_addr  = sel64 ? b_addr  : {32'b0, a_addr};
    assign o_store = sel64 ? b_store : {32'b0, a_store};
    assign o_be    = sel64 ? b_be    : {4'b0, a_be};

    // Reference model: pure byte arithmetic on the request fields.
    function automatic void model(input bit is64, input bit wen, input logic [63:0] addr,
                                  input logic [63:0] wdata, input logic [1:0] width,
                                  input bit uns, input logic [63:0] load,
                                  output bit mis, output logic [63:0] e_addr,
                                  output logic [7:0] e_be, output logic [63:0] e_store,
                                  output logic [63:0] e_rdata);
        int          bus_bytes = is64 ? 8 : 4;
        int          nb        = 1 << width;
        int          off       = int'(addr % 64'(bus_bytes));
        int          bits      = 8 * nb;
        logic [63:0] xmask     = is64 ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        logic [63:0] field;
        logic [63:0] fmask;
        mis     = (!is64 && width == 2'b11) || (addr % 64'(nb) != 0);
        e_addr  = (addr - 64'(off)) & xmask;
        e_be    = 8'(((1 << nb) - 1) << off);
        e_store = wen ? ((wdata << (8 * off)) & xmask) : 64'd0;
        field   = (load & xmask) >> (8 * off);
        fmask   = (bits == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << bits) - 64'd1);
        field   = field & fmask;
        if (!uns && field[bits-1]) field = field | ~fmask;
        e_rdata = wen ? 64'd0 : (field & xmask);
    endfunction

    task automatic txn(input bit is64, input bit wen, input logic [63:0] addr,
                       input logic [63:0] wdata, input logic [1:0] width, input bit uns,
                       input logic [63:0] load, input int delay, input string name);
        bit          mis;
        logic [63:0] e_addr, e_store, e_rdata;
        logic [7:0]  e_be;
        int          k = is64 ? 1 : 0;
        model(is64, wen, addr, wdata, width, uns, load, mis, e_addr, e_be, e_store, e_rdata);
        @(posedge clk); #1;
        sel64 = is64; req_wen = wen; req_addr = addr; req_wdata = wdata;
        req_width = width; req_unsigned = uns; req_valid = 1'b1;
        @(negedge clk);
        total++;
        if (o_ready !== 1'b1) $display("[TB] FAIL %s ready: got %b want 1", name, o_ready);
        else passed++;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        if (mis) begin
            total++;
            if ({o_valid, o_lm, o_sm, o_fault, o_rdata, o_ren, o_wen} !== {1'b1, !wen, wen, 1'b0, 64'd0, 2'b00})
                $display("[TB] FAIL %s misalign: got %b_%b%b%b_%h_%b%b want 1_%b%b0_0_00",
                         name, o_valid, o_lm, o_sm, o_fault, o_rdata, o_ren, o_wen, !wen, wen);
            else passed++;
            e_rdata = 64'd0;
            prev_flags[k] = {!wen, wen, 1'b0};
        end else begin
            total++;
            if ({o_ready, o_valid, o_ren, o_wen, o_addr, o_be, o_store, o_rdata, o_lm, o_sm, o_fault} !==
                {2'b00, !wen, wen, e_addr, e_be, e_store, prev_rdata[k], prev_flags[k]})
                $display("[TB] FAIL %s access: got %b%b%b%b a=%h be=%h st=%h rd=%h fl=%b%b%b want 00%b%b a=%h be=%h st=%h rd=%h fl=%b",
                         name, o_ready, o_valid, o_ren, o_wen, o_addr, o_be, o_store, o_rdata,
                         o_lm, o_sm, o_fault, !wen, wen, e_addr, e_be, e_store, prev_rdata[k], prev_flags[k]);
            else passed++;
            for (int i = 0; i < delay; i++) begin
                @(posedge clk);
                @(negedge clk);
                total++;
                if ({o_valid, o_ren | o_wen} !== 2'b01)
                    $display("[TB] FAIL %s wait%0d: got valid=%b strobe=%b want 0 1", name, i, o_valid, o_ren | o_wen);
                else passed++;
            end
            dhit = 1'b1;
            dmem_load = load;
            @(posedge clk); #1;
            dhit = 1'b0;
            dmem_load = {$urandom, $urandom};
            @(negedge clk);
            total++;
            if ({o_valid, o_lm, o_sm, o_fault, o_rdata, o_ren, o_wen, o_ready} !== {4'b1000, e_rdata, 3'b000})
                $display("[TB] FAIL %s resp: got %b%b%b%b rd=%h %b%b%b want 1000 rd=%h 000",
                         name, o_valid, o_lm, o_sm, o_fault, o_rdata, o_ren, o_wen, o_ready, e_rdata);
            else passed++;
            prev_flags[k] = 3'b000;
        end
        prev_rdata[k] = e_rdata;
        @(posedge clk);
        @(negedge clk);
        total++;
        if ({o_valid, o_ready, o_rdata, o_lm, o_sm, o_fault} !== {2'b01, prev_rdata[k], prev_flags[k]})
            $display("[TB] FAIL %s hold: got %b%b rd=%h fl=%b%b%b want 01 rd=%h fl=%b",
                     name, o_valid, o_ready, o_rdata, o_lm, o_sm, o_fault, prev_rdata[k], prev_flags[k]);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({a_ready, a_valid, a_lm, a_sm, a_fault, a_ren, a_wen, a_rdata, a_addr, a_be, a_store} !== {1'b1, 6'b0, 100'd0})
            $display("[TB] FAIL reset32: got %b%b%b%b%b%b%b %h %h %h %h want 1000000 all zero",
                     a_ready, a_valid, a_lm, a_sm, a_fault, a_ren, a_wen, a_rdata, a_addr, a_be, a_store);
        else passed++;
        total++;
        if ({b_ready, b_valid, b_lm, b_sm, b_fault, b_ren, b_wen, b_rdata, b_addr, b_be, b_store} !== {1'b1, 6'b0, 200'd0})
            $display("[TB] FAIL reset64: got %b%b%b%b%b%b%b %h %h %h %h want 1000000 all zero",
                     b_ready, b_valid, b_lm, b_sm, b_fault, b_ren, b_wen, b_rdata, b_addr, b_be, b_store);
        else passed++;
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            prev_rdata[k] = 64'd0;
            prev_flags[k] = 3'b000;
        end
    endtask

    task automatic test_directed();
        txn(0, 0, 64'h1003, 64'd0, 2'b00, 0, 64'h8012_3456, 0, "ld_byte_signed");
        total++;
        if (o_rdata !== 64'h0000_0000_FFFF_FF80) $display("[TB] FAIL ld_byte_value: got %h want ffffff80", o_rdata);
        else passed++;
        txn(0, 1, 64'h2002, 64'h0000_BEEF, 2'b01, 0, 64'd0, 2, "st_half");
        txn(0, 0, 64'h3001, 64'd0, 2'b10, 0, 64'd0, 0, "ld_word_misaligned");
        txn(0, 1, 64'h10, 64'h1234, 2'b11, 0, 64'd0, 0, "st_double_on_32");
        txn(1, 0, 64'h4008, 64'd0, 2'b11, 1, 64'h8000_0000_0000_0001, 0, "ld_double_64");
        total++;
        if (o_rdata !== 64'h8000_0000_0000_0001) $display("[TB] FAIL ld_double_value: got %h want 8000000000000001", o_rdata);
        else passed++;
        txn(1, 0, 64'h4006, 64'd0, 2'b01, 0, 64'h1234_8000_0000_0000, 1, "ld_half_top_64");
    endtask

    task automatic test_dhit_idle();
        sel64 = 1'b0;
        @(posedge clk); #1;
        dhit = 1'b1;
        @(posedge clk); #1;
        dhit = 1'b0;
        @(negedge clk);
        total++;
        if ({o_valid, o_ready, o_ren, o_wen} !== 4'b0100)
            $display("[TB] FAIL dhit_idle: got %b%b%b%b want 0100", o_valid, o_ready, o_ren, o_wen);
        else passed++;
    endtask

    task automatic test_reset_mid_access();
        bit seen = 1'b0;
        @(posedge clk); #1;
        sel64 = 1'b0; req_wen = 1'b0; req_addr = 64'h5000; req_width = 2'b10;
        req_unsigned = 1'b0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({o_ready, o_valid, o_ren, o_wen, o_be, o_rdata} !== {4'b1000, 72'd0})
            $display("[TB] FAIL rst_mid_access: got %b%b%b%b be=%h rd=%h want 1000 0 0", o_ready, o_valid, o_ren, o_wen, o_be, o_rdata);
        else passed++;
        for (int k = 0; k < 2; k++) begin
            prev_rdata[k] = 64'd0;
            prev_flags[k] = 3'b000;
        end
        repeat (4) begin
            @(negedge clk);
            if (o_valid) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) $display("[TB] FAIL rst_no_resp: got resp_valid=1 want none");
        else passed++;
        txn(0, 0, 64'h5000, 64'd0, 2'b10, 0, 64'hCAFE_F00D, 0, "after_rst");
    endtask

    task automatic test_watchdog();
        bit stuck = 1'b1;
        @(posedge clk); #1;
        sel64 = 1'b0; req_wen = 1'b0; req_addr = 64'h6004; req_width = 2'b10;
        req_unsigned = 1'b0; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
`ifdef LSU_TIMEOUT_EN
        for (int i = 1; i < TO; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (!(o_ren && !o_valid)) stuck = 1'b0;
        end
        total++;
        if (stuck !== 1'b1) $display("[TB] FAIL wd_early: got early exit from ACCESS want wait");
        else passed++;
        @(posedge clk);
        @(negedge clk);
        total++;
        if ({o_valid, o_lm, o_sm, o_fault, o_rdata, o_ren, o_wen} !== {4'b1001, 64'd0, 2'b00})
            $display("[TB] FAIL wd_fault: got %b%b%b%b rd=%h %b%b want 1001 rd=0 00",
                     o_valid, o_lm, o_sm, o_fault, o_rdata, o_ren, o_wen);
        else passed++;
        prev_rdata[0] = 64'd0;
        prev_flags[0] = 3'b001;
`else
        repeat (3 * TO) begin
            @(posedge clk);
            @(negedge clk);
            if (!(o_ren && !o_valid && !o_ready && !o_fault)) stuck = 1'b0;
        end
        total++;
        if (stuck !== 1'b1) $display("[TB] FAIL wd_absent: got exit from ACCESS want wait for dhit");
        else passed++;
        dhit = 1'b1;
        dmem_load = 64'h0000_0000_0000_00A5;
        @(posedge clk); #1;
        dhit = 1'b0;
        @(negedge clk);
        total++;
        if ({o_valid, o_fault, o_rdata} !== {2'b10, 64'h0000_0000_0000_00A5})
            $display("[TB] FAIL wd_late_hit: got %b%b rd=%h want 10 rd=a5", o_valid, o_fault, o_rdata);
        else passed++;
        prev_rdata[0] = 64'h0000_0000_0000_00A5;
        prev_flags[0] = 3'b000;
`endif
        @(posedge clk);
        txn(0, 0, 64'h6004, 64'd0, 2'b00, 1, 64'h0000_7700_0000_0000, 1, "after_wd");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            bit          is64 = 1'($urandom_range(0, 1));
            logic [63:0] addr = is64 ? {$urandom, $urandom} : {32'd0, $urandom};
            txn(is64, 1'($urandom_range(0, 1)), addr, {$urandom, $urandom},
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), {$urandom, $urandom},
                $urandom_range(0, TO - 1), "random");
        end
    endtask

    initial begin
        rst = 1'b1; sel64 = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_unsigned = 1'b0;
        dhit = 1'b0; req_addr = '0; req_wdata = '0; dmem_load = '0; req_width = 2'b00;
        test_reset();
        test_directed();
        test_dhit_idle();
        test_reset_mid_access();
        test_watchdog();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
